// File: rtl/trdb_packet_decoder_if.sv
// Trace packet types and the packet handshake bus feeding trdb_packet_decoder.
// The enum encodings follow the trace encoder's packet format fields.
typedef enum logic [1:0] {
  F_OPT_EXT    = 2'd0,
  F_DIFF_DELTA = 2'd1,
  F_ADDR_ONLY  = 2'd2,
  F_SYNC       = 2'd3
} trdb_format_e;

typedef enum logic [1:0] {
  SF_START   = 2'd0,
  SF_TRAP    = 2'd1,
  SF_CONTEXT = 2'd2,
  SF_SUPPORT = 2'd3
} trdb_f_sync_subformat_e;

typedef enum logic [1:0] {
  NO_CHANGE  = 2'd0,
  ENDED_REP  = 2'd1,
  TRACE_LOST = 2'd2,
  ENDED_NTR  = 2'd3
} qual_status_e;

interface trdb_packet_decoder_if #(
  parameter int XLEN         = 32,
  parameter int MAX_BRANCHES = 31
) ();
  localparam int KW = $clog2(XLEN) + 1;

  logic                   valid_i;
  logic                   ready_o;
  trdb_format_e           packet_format_i;
  trdb_f_sync_subformat_e packet_f_sync_subformat_i;
  logic [4:0]             branches_i;
  logic [MAX_BRANCHES-1:0] branch_map_i;
  logic [XLEN-1:0]        addr_i;
  logic [KW-1:0]          keep_bits_i;
  logic                   thaddr_i;
  qual_status_e           qual_status_i;

  modport master (
    output valid_i, packet_format_i, packet_f_sync_subformat_i, branches_i,
           branch_map_i, addr_i, keep_bits_i, thaddr_i, qual_status_i,
    input  ready_o
  );

  modport slave (
    input  valid_i, packet_format_i, packet_f_sync_subformat_i, branches_i,
           branch_map_i, addr_i, keep_bits_i, thaddr_i, qual_status_i,
    output ready_o
  );
endinterface

// File: rtl/trdb_packet_decoder.sv
// Trace packet decoder: serializes branch maps and rebuilds PCs from compressed addresses.
// Define TRDB_DEC_FULL_ADDR_EN to treat F_DIFF_DELTA/F_ADDR_ONLY addresses as absolute.
module trdb_packet_decoder #(
  parameter int XLEN         = 32,
  parameter int MAX_BRANCHES = 31
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  trdb_packet_decoder_if.slave  pkt,
  output logic                  branch_valid_o,
  output logic                  branch_taken_o,
  output logic                  addr_valid_o,
  output logic [XLEN-1:0]       addr_o,
  output logic                  trap_o,
  output logic                  synced_o,
  output qual_status_e          qual_status_o,
  output logic                  err_o
);

  localparam int KW = $clog2(XLEN) + 1;

`ifdef TRDB_DEC_FULL_ADDR_EN
  localparam bit FullAddr = 1'b1;
`else
  localparam bit FullAddr = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BRANCH, S_ADDR, S_BUSY} state_e;

  state_e                  r_state, w_next_state;
  logic [4:0]              r_cnt;
  logic [MAX_BRANCHES-1:0] r_map;
  logic [XLEN-1:0]         r_addr;
  logic [XLEN-1:0]         r_last_addr;
  logic                    r_has_addr, r_trap, r_err;
  logic                    r_synced;
  qual_status_e            r_qual;

  logic                    w_accept;
  logic [4:0]              w_nb;
  logic                    w_has_addr, w_drop, w_trap, w_sets_sync, w_support;
  logic [XLEN-1:0]         w_sext, w_target;
  logic                    w_unused;

  // Keep bits [k-1:0], replicate bit k-1 upward; k=0 or k>XLEN means no extension.
  function automatic logic [XLEN-1:0] sext(input logic [XLEN-1:0] a, input logic [KW-1:0] k);
    int              kk;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] sh;
    kk = (k == '0 || int'(k) > XLEN) ? XLEN : int'(k);
    hi = {XLEN{1'b1}} << kk;
    sh = a >> (kk - 1);
    return sh[0] ? (a | hi) : (a & ~hi);
  endfunction

  assign w_accept = pkt.valid_i && (r_state == S_IDLE);
  assign w_sext   = sext(pkt.addr_i, pkt.keep_bits_i);
  assign w_unused = ^{pkt.thaddr_i, r_last_addr};

  always_comb begin
    w_nb        = 5'd0;
    w_has_addr  = 1'b0;
    w_drop      = 1'b0;
    w_trap      = 1'b0;
    w_sets_sync = 1'b0;
    w_support   = 1'b0;
    w_target    = w_sext;
    case (pkt.packet_format_i)
      F_SYNC: begin
        case (pkt.packet_f_sync_subformat_i)
          SF_START:   begin w_has_addr = 1'b1; w_sets_sync = 1'b1; end
          SF_TRAP:    begin w_has_addr = 1'b1; w_sets_sync = 1'b1; w_trap = 1'b1; end
          SF_SUPPORT: w_support = 1'b1;
          default:    w_drop = 1'b1;
        endcase
      end
      F_DIFF_DELTA, F_ADDR_ONLY: begin
        if (!r_synced && !FullAddr) begin
          w_drop = 1'b1;
        end else begin
          if (!FullAddr) w_target = r_last_addr + w_sext;
          if (pkt.packet_format_i == F_ADDR_ONLY) begin
            w_has_addr = 1'b1;
          end else begin
            w_nb       = (pkt.branches_i == 5'd0) ? 5'(MAX_BRANCHES) : pkt.branches_i;
            w_has_addr = (pkt.branches_i != 5'd0);
          end
        end
      end
      default: w_drop = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_drop || w_support) w_next_state = S_BUSY;
          else if (w_nb != 5'd0)   w_next_state = S_BRANCH;
          else                     w_next_state = S_ADDR;
        end
      end
      S_BRANCH: if (r_cnt == 5'd1) w_next_state = r_has_addr ? S_ADDR : S_IDLE;
      S_ADDR:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    pkt.ready_o    = (r_state == S_IDLE);
    branch_valid_o = (r_state == S_BRANCH);
    branch_taken_o = (r_state == S_BRANCH) && r_map[0];
    addr_valid_o   = (r_state == S_ADDR);
    addr_o         = (r_state == S_ADDR) ? r_addr : '0;
    trap_o         = (r_state == S_ADDR) && r_trap;
    err_o          = (r_state == S_BUSY) && r_err;
    synced_o       = r_synced;
    qual_status_o  = r_qual;
  end

  // Architectural state: sync flag, qualification status and the differential base.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_synced    <= 1'b0;
      r_qual      <= NO_CHANGE;
      r_last_addr <= '0;
    end else begin
      if (w_accept && w_sets_sync) r_synced <= 1'b1;
      if (w_accept && w_support) begin
        r_qual <= pkt.qual_status_i;
        if (pkt.qual_status_i == ENDED_NTR || pkt.qual_status_i == ENDED_REP) r_synced <= 1'b0;
      end
      if (r_state == S_ADDR) r_last_addr <= r_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_map      <= pkt.branch_map_i;
      r_cnt      <= w_nb;
      r_addr     <= w_target;
      r_has_addr <= w_has_addr;
      r_trap     <= w_trap;
      r_err      <= w_drop;
    end else if (r_state == S_BRANCH) begin
      r_map <= r_map >> 1;
      r_cnt <= r_cnt - 5'd1;
    end
  end

endmodule
